// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if: SPI pins plus the RAM-side command/response handshake
interface spi_slave_if_if #(parameter int DATA_W = 8);
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic [DATA_W+1:0] rx_data;
  logic rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic tx_valid;
  modport slave(input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid);
  modport master(output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave deserialising command words for the RAM and serialising read data on MISO
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  spi_slave_if_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 3);
  localparam int TW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_W + 2);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DATA_W:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [TW-1:0] tx_left;
  logic tx_used, rd_addr_seen;
  logic shifting, last_bit, tx_wait;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = bus.SS_n ? IDLE : CHK_CMD;
    else if (bus.SS_n) state_n = IDLE;
    else if (state == CHK_CMD) state_n = !bus.MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD;
  end
  assign shifting = state inside {WRITE, READ_ADD, READ_DATA};
  assign last_bit = shifting && cnt == FULL - 1'b1;
  // the RAM can only answer after it has seen rx_valid, so the rx_valid cycle is excluded
  assign tx_wait = state == READ_DATA && cnt == FULL && !bus.rx_valid && !tx_used;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      tx_left <= '0;
      tx_used <= 1'b0;
      rd_addr_seen <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.MISO <= 1'b0;
    end else if (state == IDLE || bus.SS_n) begin
      cnt <= '0;
      tx_left <= '0;
      tx_used <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.MISO <= 1'b0;
    end else begin
      bus.rx_valid <= last_bit;
      if (shifting && cnt != FULL) begin
        rx_sr <= {rx_sr[DATA_W-1:0], bus.MOSI};
        cnt <= cnt + 1'b1;
      end
      if (last_bit) begin
        bus.rx_data <= {rx_sr, bus.MOSI};
        if (state == READ_ADD) rd_addr_seen <= 1'b1;
        else if (state == READ_DATA) rd_addr_seen <= 1'b0;
      end
      if (tx_wait && bus.tx_valid) begin
        tx_sr <= bus.tx_data;
        tx_used <= 1'b1;
        tx_left <= TW'(DATA_W);
      end else if (tx_left != '0) begin
        bus.MISO <= tx_sr[DATA_W-1];
        tx_sr <= tx_sr << 1;
        tx_left <= tx_left - 1'b1;
      end else begin
        bus.MISO <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: frame-level reference model with per-cycle output comparison
module tb_spi_slave_if;
  localparam int MAXC = 20000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit m_seen = 1'b0;
  int n_rxv = 0;
  logic [9:0] last_rx = '0;
  bit exp_rxv[MAXC];
  bit exp_miso[MAXC];
  bit obs_miso[MAXC];
  logic [9:0] exp_rxd[MAXC];
  spi_slave_if_if #(.DATA_W(8)) bus();
  spi_slave_if #(.DATA_W(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (chk_en && cyc < MAXC) begin
      obs_miso[cyc] = bus.MISO;
      if (bus.rx_valid === 1'b1) begin
        n_rxv++;
        last_rx = bus.rx_data;
      end
      checks++;
      if (bus.rx_valid !== exp_rxv[cyc]) begin
        errors++;
        $display("FAIL rx_valid cyc=%0d got %b expected %b", cyc, bus.rx_valid, exp_rxv[cyc]);
      end
      checks++;
      if (bus.MISO !== exp_miso[cyc]) begin
        errors++;
        $display("FAIL miso cyc=%0d got %b expected %b", cyc, bus.MISO, exp_miso[cyc]);
      end
      if (exp_rxv[cyc]) begin
        checks++;
        if (bus.rx_data !== exp_rxd[cyc]) begin
          errors++;
          $display("FAIL rx_data cyc=%0d got %h expected %h", cyc, bus.rx_data, exp_rxd[cyc]);
        end
      end
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  // L edges with SS_n low starting at edge k; txo = offset of the real tx_valid pulse;
  // spur adds random tx_valid pulses plus one forced in the rx_valid cycle; rst_at aborts by reset
  task automatic frame(input bit sel, input logic [9:0] w, input int L, input int txo,
                       input logic [7:0] txd, input bit spur, input int rst_at, output int k);
    bit txv[64];
    bit mo[64];
    logic [7:0] td[64];
    int lim, j;
    bit ra, rd;
    k = cyc + 1;
    lim = rst_at >= 0 ? rst_at : 64;
    for (int o = 0; o < L; o++) begin
      txv[o] = (o == txo) || (spur && (o == 12 || $urandom_range(0, 1) == 1));
      td[o] = o == txo ? txd : 8'($urandom);
      mo[o] = o == 1 ? sel : (o >= 2 && o <= 11) ? w[11-o] : 1'($urandom);
    end
    ra = sel && !m_seen;
    rd = sel && m_seen;
    if (L >= 12 && 11 < lim) begin
      exp_rxv[k+11] = 1'b1;
      exp_rxd[k+11] = w;
      if (ra) m_seen = 1'b1;
      if (rd) m_seen = 1'b0;
    end
    if (rd && L >= 12) begin
      j = -1;
      for (int o = 13; o < L; o++) if (txv[o] && j < 0) j = o;
      if (j >= 0)
        for (int i = 0; i < 8; i++)
          if (j + 1 + i < L && j + 1 + i < lim) exp_miso[k+j+1+i] = td[j][7-i];
    end
    if (rst_at >= 0) m_seen = 1'b0;
    for (int o = 0; o < L; o++) begin
      bus.SS_n = 1'b0;
      bus.MOSI = mo[o];
      bus.tx_valid = txv[o];
      bus.tx_data = td[o];
      tick();
      if (o == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_miso", 32'(bus.MISO), 0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 0);
        chk("rst_rx_data", 32'(bus.rx_data), 0);
        break;
      end
    end
    bus.SS_n = 1'b1;
    bus.tx_valid = 1'b0;
    tick();
    if (rst_at >= 0) begin
      rst = 1'b0;
      tick();
    end
  endtask
  initial begin
    int k, n0, ones;
    logic [7:0] b;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    tick();
    tick();
    chk("reset_miso", 32'(bus.MISO), 0);
    chk("reset_rx_valid", 32'(bus.rx_valid), 0);
    chk("reset_rx_data", 32'(bus.rx_data), 0);
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    n0 = n_rxv;
    frame(1'b0, 10'h005, 12, -1, 8'h00, 1'b0, -1, k);
    chk("wr_addr_pulses", 32'(n_rxv - n0), 1);
    chk("wr_addr_word", 32'(last_rx), 32'h005);
    n0 = n_rxv;
    frame(1'b0, 10'h1AA, 17, -1, 8'h00, 1'b0, -1, k);
    chk("wr_data_pulses", 32'(n_rxv - n0), 1);
    chk("wr_data_word", 32'(last_rx), 32'h1AA);
    frame(1'b1, 10'h205, 12, -1, 8'h00, 1'b0, -1, k);
    chk("rd_addr_word", 32'(last_rx), 32'h205);
    frame(1'b1, 10'h300, 30, 13, 8'hAA, 1'b0, -1, k);
    chk("rd_data_word", 32'(last_rx), 32'h300);
    b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], obs_miso[k+14+i]};
    chk("miso_aa", 32'(b), 32'hAA);
    chk("miso_tail", 32'(obs_miso[k+22]), 0);
    n0 = n_rxv;
    frame(1'b0, 10'h155, 8, -1, 8'h00, 1'b0, -1, k);
    chk("abort_pulses", 32'(n_rxv - n0), 0);
    frame(1'b0, 10'h0F0, 12, -1, 8'h00, 1'b0, -1, k);
    chk("after_abort_word", 32'(last_rx), 32'h0F0);
    frame(1'b0, 10'h133, 25, 14, 8'hFF, 1'b1, -1, k);
    ones = 0;
    for (int i = 0; i < 25; i++) ones += obs_miso[k+i];
    chk("spurious_miso", 32'(ones), 0);
    frame(1'b1, 10'h211, 12, -1, 8'h00, 1'b0, -1, k);
    frame(1'b1, 10'h311, 30, 13, 8'h3C, 1'b0, 17, k);
    chk("pre_rst_miso", 32'(obs_miso[k+16]), 1);
    frame(1'b1, 10'h210, 30, 13, 8'h55, 1'b0, -1, k);
    ones = 0;
    for (int i = 0; i < 30; i++) ones += obs_miso[k+i];
    chk("post_rst_read_add", 32'(ones), 0);
    chk("post_rst_word", 32'(last_rx), 32'h210);
    for (int f = 0; f < 150; f++) begin
      int L;
      L = $urandom_range(0, 3) == 0 ? $urandom_range(1, 11) : $urandom_range(12, 40);
      repeat ($urandom_range(0, 2)) tick();
      frame(1'($urandom), 10'($urandom), L, $urandom_range(10, L), 8'($urandom),
            $urandom_range(0, 3) == 0, -1, k);
    end
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front end that sits directly upstream of the single-port RAM.
- Deserialises MOSI frames into 10-bit command words (2-bit opcode + 8-bit payload) and pulses rx_valid toward the RAM.
- On a read-data frame, captures the RAM's 8-bit response on tx_valid and serialises it MSB-first on MISO.
- The SPI bit clock is clk; MOSI and SS_n are synchronous to clk.

Parameters:
- DATA_W, 8, RAM payload width; rx_data is DATA_W+2 bits, tx_data is DATA_W bits.

Ports:
- clk  input  1  system clock; also the SPI bit clock; all sampling on the rising edge
- rst  input  1  asynchronous reset, active-high
- SS_n  input  1  slave select, active-low; high aborts or ends a frame
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out, MSB first
- rx_data  output  DATA_W+2  command word to RAM ({opcode[1:0], payload})
- rx_valid  output  1  one-cycle strobe; rx_data is valid while high
- tx_data  input  DATA_W  read data from RAM
- tx_valid  input  1  tx_data valid strobe from RAM

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0, tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. From any non-IDLE state, SS_n sampled high -> IDLE next edge.
- On entering IDLE: counter cleared, rx_valid=0, MISO=0. rx_data and rd_addr_seen are held.
- IDLE: SS_n sampled low at edge k -> CHK_CMD.
- CHK_CMD, edge k+1: MOSI is the selector bit and is not stored.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- Shift phase (WRITE, READ_ADD, READ_DATA), edges k+2..k+11:
  - MOSI shifts into the rx shift register MSB-first, 10 bits.
  - At edge k+11, rx_data is loaded with the full word and rx_valid=1 for exactly one cycle (cleared at edge k+12).
  - Shifting latency: 10 clocks from the selector bit to rx_valid.
- After rx_valid in WRITE or READ_ADD: hold state, ignore further MOSI, no further rx_valid until SS_n high. READ_ADD additionally sets rd_addr_seen=1 at the rx_valid edge.
- The opcode bits in rx_data are forwarded unchanged; the block does not check them against the state.
- READ_DATA, after rx_valid:
  - rd_addr_seen cleared at the rx_valid edge.
  - Wait for tx_valid. The first edge with tx_valid=1 loads tx_data into the tx shift register.
  - Starting the next edge, MISO drives tx_data[DATA_W-1] down to tx_data[0], one bit per clock, each bit held one full cycle.
  - After DATA_W bits, MISO=0 and tx_valid is ignored until the next frame.
- tx_valid is ignored in all states except READ_DATA-waiting. This includes tx_valid high before or during the rx_valid cycle.
- SS_n high mid-shift or mid-serialisation aborts the frame:
  - No rx_valid for partial words.
  - MISO returns to 0.
  - rd_addr_seen is unchanged unless its set/clear edge has already occurred.
- SS_n low in IDLE on the same edge rst deasserts: no effect until the next edge (reset dominates).
- rst asserted mid-frame: immediate return to reset values, including rd_addr_seen=0.

Test Plan:
- Write address: SS_n low, MOSI = 0 then 00_0000_0101 -> rx_valid one cycle at edge k+11, rx_data=10'h005; SS_n high -> IDLE.
- Write data: frame 0 + 01_1010_1010 -> rx_data=10'h1AA, single rx_valid pulse; 5 extra MOSI bits before SS_n high -> no second pulse.
- Read address then data:
  - Frame 1 + 10_0000_0101 -> rx_data=10'h205, rd_addr_seen=1.
  - Frame 1 + 11_0000_0000 -> rx_data=10'h300.
  - tx_valid with tx_data=8'hAA two cycles later -> MISO = 1,0,1,0,1,0,1,0 on the following 8 edges, then 0; rd_addr_seen=0.
- Abort: SS_n high after 6 payload bits of a WRITE frame -> no rx_valid, state IDLE; the next full frame decodes correctly.
- Spurious tx_valid: tx_valid=1 with tx_data=8'hFF during a WRITE frame -> MISO stays 0.
- Async reset: rst pulsed mid-serialisation of 8'h3C -> MISO=0, rx_valid=0 immediately; the next read frame goes to READ_ADD.
